// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with run-time frame format
// Optional feature: define UART_TX_BREAK_EN to add the break_req input and BREAK state.
module uart_tx_fifo #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVERSAMPLING  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_16x,
  input  logic [3:0]                   cfg_data_bits,
  input  logic                         cfg_parity_en,
  input  logic [1:0]                   cfg_parity_mode,
  input  logic [1:0]                   cfg_stop,
  input  logic                         cts,
  input  logic                         flush,
`ifdef UART_TX_BREAK_EN
  input  logic                         break_req,
`endif
  input  logic                         wr_valid,
  input  logic [MAX_DATA_BITS-1:0]     wr_data,
  output logic                         wr_ready,
  output logic                         tx_out,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * OVERSAMPLING) + 1;

  localparam logic [TW-1:0] BIT_TICKS   = TW'(OVERSAMPLING);
  localparam logic [TW-1:0] STOP15_TICKS = TW'(OVERSAMPLING + OVERSAMPLING / 2);
  localparam logic [TW-1:0] STOP2_TICKS  = TW'(2 * OVERSAMPLING);

  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Break lasts at least as long as the longest possible frame.
  localparam int BRK_BITS = MAX_DATA_BITS + 4;
  localparam int BW       = $clog2(BRK_BITS);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRK_BITS - 1);

  logic [BW-1:0] brk_cnt;
  logic          brk_q;
`endif

  logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  logic [MAX_DATA_BITS-1:0] head;

  logic [2:0]               state;
  logic [TW-1:0]            tick_cnt;
  logic [3:0]               bit_idx;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic [3:0]               nbits_q;
  logic                     par_en_q;
  logic                     par_q;
  logic [1:0]               stop_q;

  logic [3:0]               n_eff;
  logic                     head_xor;
  logic                     par_next;
  logic [TW-1:0]            stop_limit;
  logic [TW-1:0]            cur_limit;
  logic                     tick_last;

  assign wr_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = wr_valid && wr_ready && !flush;
  assign head       = mem[rd_ptr];
  assign tx_busy    = (state != S_IDLE);

`ifdef UART_TX_BREAK_EN
  assign pop = (state == S_IDLE) && !fifo_empty && cts && !break_req;
`else
  assign pop = (state == S_IDLE) && !fifo_empty && cts;
`endif

  // FIFO storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; flush drops any same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Clamp the requested data width into the supported range
  always_comb begin
    n_eff = cfg_data_bits;
    if (cfg_data_bits < MIN_BITS)      n_eff = MIN_BITS;
    else if (cfg_data_bits > MAX_BITS) n_eff = MAX_BITS;
  end

  // Parity of the head word over only the bits that will be sent
  always_comb begin
    head_xor = 1'b0;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (4'(i) < n_eff) head_xor = head_xor ^ head[i];
    end
    case (cfg_parity_mode)
      2'b00:   par_next = head_xor;
      2'b01:   par_next = ~head_xor;
      2'b10:   par_next = 1'b1;
      default: par_next = 1'b0;
    endcase
  end

  // Tick budget of the current bit; only STOP differs from one bit period
  always_comb begin
    case (stop_q)
      2'b00:   stop_limit = BIT_TICKS;
      2'b01:   stop_limit = STOP15_TICKS;
      default: stop_limit = STOP2_TICKS;
    endcase
    cur_limit = (state == S_STOP) ? stop_limit : BIT_TICKS;
    tick_last = tick_16x && (tick_cnt == cur_limit - TW'(1));
  end

  // Frame sequencer; tx_out is registered and moves with state/bit changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      nbits_q  <= MIN_BITS;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= 2'b00;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt  <= '0;
      brk_q    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (tick_last)     tick_cnt <= '0;
      else if (tick_16x) tick_cnt <= tick_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          bit_idx  <= '0;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state   <= S_BREAK;
            tx_out  <= 1'b0;
            brk_cnt <= '0;
            brk_q   <= 1'b1;
            stop_q  <= 2'b00;
          end else
`endif
          if (pop) begin
            state    <= S_START;
            tx_out   <= 1'b0;
            data_q   <= head;
            nbits_q  <= n_eff;
            par_en_q <= cfg_parity_en;
            par_q    <= par_next;
            stop_q   <= cfg_stop;
`ifdef UART_TX_BREAK_EN
            brk_q    <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick_last) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_out  <= data_q[0];
            data_q  <= data_q >> 1;
          end
        end
        S_DATA: begin
          if (tick_last) begin
            if (bit_idx == nbits_q - 4'd1) begin
              if (par_en_q) begin
                state  <= S_PARITY;
                tx_out <= par_q;
              end else begin
                state  <= S_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_out  <= data_q[0];
              data_q  <= data_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (tick_last) begin
            state  <= S_STOP;
            tx_out <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick_last) begin
            state   <= S_IDLE;
`ifdef UART_TX_BREAK_EN
            tx_done <= !brk_q;
`else
            tx_done <= 1'b1;
`endif
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (tick_last) begin
            if (brk_cnt != BRK_LAST) begin
              brk_cnt <= brk_cnt + BW'(1);
            end else if (!break_req) begin
              state  <= S_STOP;
              tx_out <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int MDB   = 9;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick_16x = 1'b0;
  logic [3:0]     cfg_data_bits = 4'd8;
  logic           cfg_parity_en = 1'b1;
  logic [1:0]     cfg_parity_mode = 2'b00;
  logic [1:0]     cfg_stop = 2'b00;
  logic           cts = 1'b1;
  logic           flush = 1'b0;
  logic           wr_valid = 1'b0;
  logic [MDB-1:0] wr_data = '0;
`ifdef UART_TX_BREAK_EN
  logic           break_req = 1'b0;
`endif
  logic           wr_ready;
  logic           tx_out;
  logic           tx_busy;
  logic           tx_done;
  logic [4:0]     fifo_count;

  int errors = 0;
  int checks = 0;
  int tcnt = 0;
  int done_cnt = 0;

  uart_tx_fifo #(.MAX_DATA_BITS(MDB), .FIFO_DEPTH(DEPTH), .OVERSAMPLING(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_mode(cfg_parity_mode), .cfg_stop(cfg_stop),
    .cts(cts), .flush(flush),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // one-clk tick every fourth clock, driven on falling edges
  initial begin
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        tick_16x = (i == 3);
      end
    end
  end

  // tick and tx_done counters used as the time base for bit checks
  always @(posedge clk) begin
    if (tick_16x) tcnt <= tcnt + 1;
    if (tx_done)  done_cnt <= done_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int target);
    while (tcnt < target) @(negedge clk);
  endtask

  task automatic push(input logic [MDB-1:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_low(output bit ok);
    int guard;
    guard = 0;
    while (tx_out !== 1'b0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    ok = (tx_out === 1'b0);
  endtask

  task automatic check_frame(input string tag, input int n, input logic [MDB-1:0] exp_d,
                             input bit pe, input bit exp_p, input int stop_ticks);
    int t0;
    int guard;
    bit ok;
    logic [MDB-1:0] d;
    wait_low(ok);
    if (!ok) begin
      check({tag, "_start_seen"}, 32'(tx_out), 32'd0);
      return;
    end
    t0 = tcnt;
    check({tag, "_busy"}, 32'(tx_busy), 32'd1);
    wait_tick(t0 + 8);
    check({tag, "_startbit"}, 32'(tx_out), 32'd0);
    d = '0;
    for (int k = 0; k < n; k++) begin
      wait_tick(t0 + 16 * (k + 1) + 8);
      d[k] = tx_out;
    end
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    if (pe) begin
      wait_tick(t0 + 16 * (n + 1) + 8);
      check({tag, "_parity"}, 32'(tx_out), 32'(exp_p));
    end
    wait_tick(t0 + 16 * (n + 1 + int'(pe)) + 8);
    check({tag, "_stopbit"}, 32'(tx_out), 32'd1);
    guard = 0;
    while (tx_done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_len_ticks"}, 32'(tcnt - t0), 32'(16 * (1 + n + int'(pe)) + stop_ticks));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    int t0;
    int d0;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8E1, 0x55
    push(9'h055);
    check("t1_count1", 32'(fifo_count), 32'd1);
    check_frame("t1", 8, 9'h055, 1'b1, 1'b0, 16);
    check("t1_count0", 32'(fifo_count), 32'd0);
    check("t1_done_once", 32'(done_cnt), 32'd1);

    // 7O2, upper bits of 0x1C1 ignored
    cfg_data_bits = 4'd7; cfg_parity_mode = 2'b01; cfg_stop = 2'b10;
    push(9'h1C1);
    check_frame("t2", 7, 9'h041, 1'b1, 1'b1, 32);

    // CTS gating
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop = 2'b00;
    cts = 1'b0;
    push(9'h011); push(9'h022); push(9'h033);
    repeat (200) @(negedge clk);
    check("t3_idle_line", 32'(tx_out), 32'd1);
    check("t3_idle_busy", 32'(tx_busy), 32'd0);
    check("t3_count3", 32'(fifo_count), 32'd3);
    cts = 1'b1;
    fork
      check_frame("t3a", 8, 9'h011, 1'b0, 1'b0, 16);
      begin
        repeat (100) @(negedge clk);
        cts = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    check("t3_wait_line", 32'(tx_out), 32'd1);
    check("t3_wait_count", 32'(fifo_count), 32'd2);
    cts = 1'b1;
    check_frame("t3b", 8, 9'h022, 1'b0, 1'b0, 16);
    check_frame("t3c", 8, 9'h033, 1'b0, 1'b0, 16);

    // full FIFO, overflow drop, flush
    cts = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_data  = 9'(i + 1);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("t4_full_count", 32'(fifo_count), 32'd16);
    check("t4_full_ready", 32'(wr_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_flush_count", 32'(fifo_count), 32'd0);
    check("t4_flush_ready", 32'(wr_ready), 32'd1);
    wr_data = 9'h0AB; wr_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; flush = 1'b0;
    check("t4_flush_beats_push", 32'(fifo_count), 32'd0);
    push(9'h0CD);
    cts = 1'b1;
    check_frame("t4_after_flush", 8, 9'h0CD, 1'b0, 1'b0, 16);

    // 9M1.5, then reset in the middle of DATA
    cfg_data_bits = 4'd9; cfg_parity_en = 1'b1; cfg_parity_mode = 2'b10; cfg_stop = 2'b01;
    push(9'h1AA);
    check_frame("t5", 9, 9'h1AA, 1'b1, 1'b1, 24);
    push(9'h1AA);
    push(9'h155);
    wait_low(ok);
    check("t5_second_started", 32'(ok), 32'd1);
    t0 = tcnt;
    wait_tick(t0 + 40);
    check("t5_mid_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_line", 32'(tx_out), 32'd1);
    check("t5_rst_busy", 32'(tx_busy), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef UART_TX_BREAK_EN
    // break takes priority over a queued word, then the word goes out
    cts = 1'b0;
    push(9'h00F);
    break_req = 1'b1; cts = 1'b1;
    @(negedge clk);
    break_req = 1'b0;
    t0 = tcnt;
    check("brk_line_low", 32'(tx_out), 32'd0);
    check("brk_no_pop", 32'(fifo_count), 32'd1);
    d0 = 0;
    while (tx_out !== 1'b1 && d0 < 5000) begin
      @(negedge clk);
      d0++;
    end
    check("brk_len_ticks", 32'(tcnt - t0), 32'd208);
    d0 = done_cnt;
    check_frame("brk_frame", 9, 9'h00F, 1'b1, 1'b1, 24);
    check("brk_done_count", 32'(done_cnt - d0), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
